// File: rtl/wb_write_arbiter_pkg.sv
// Shared register-file write-port definitions for the WB/mul-div write arbiter.
package wb_write_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    SlotIdle,
    SlotWb,
    SlotMd
  } slot_e;

  function automatic logic [NUM_REGS-1:0] reg_bit(input logic [REG_ADDR_W-1:0] addr);
    logic [NUM_REGS-1:0] mask;
    mask       = '0;
    mask[addr] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/wb_write_arbiter_fifo.sv
// Small circular FIFO holding out-of-order mul/div results until a write slot is free.
module wb_write_arbiter_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 37
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [Width-1:0]           wdata,
  output logic [Width-1:0]           head,
  output logic [$clog2(Depth+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CntW'(Depth));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while count covers them.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: WB results win, buffered mul/div results fill idle slots,
// and a pending scoreboard tracks mul/div destinations not yet written.
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_wr,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  md_issue,
  input  logic [REG_ADDR_W-1:0] md_iaddr,
  input  logic                  md_valid,
  output logic                  md_ready,
  input  logic [REG_ADDR_W-1:0] md_addr,
  input  logic [DATA_W-1:0]     md_data,
  output logic                  rf_wr,
  output logic [REG_ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0]     rf_data,
  output logic [NUM_REGS-1:0]   pend_mask,
  output logic                  stall_req
);

  localparam int unsigned EntryW = REG_ADDR_W + DATA_W;

  logic                          wb_take;
  logic                          fifo_push, fifo_pop;
  logic                          fifo_full, fifo_empty;
  logic [EntryW-1:0]             fifo_head;
  logic [$clog2(DEPTH+1)-1:0]    fifo_count;
  logic [REG_ADDR_W-1:0]         head_addr;
  logic [DATA_W-1:0]             head_data;
  slot_e                         slot;

  logic                  rf_wr_q, rf_wr_d;
  logic [REG_ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0]     rf_data_q, rf_data_d;
  logic [NUM_REGS-1:0]   pend_q, pend_d;

  assign wb_take   = wb_wr && (wb_addr != REG_ZERO);
  assign md_ready  = !fifo_full;
  assign stall_req = fifo_full;
  // Address-0 results complete the handshake but never enter the FIFO.
  assign fifo_push = md_valid && md_ready && (md_addr != REG_ZERO);
  assign fifo_pop  = !wb_take && !fifo_empty;
  assign head_addr = fifo_head[EntryW-1 -: REG_ADDR_W];
  assign head_data = fifo_head[DATA_W-1:0];

  wb_write_arbiter_fifo #(
    .Depth (DEPTH),
    .Width (EntryW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({md_addr, md_data}),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    slot = SlotIdle;
    if (wb_take) begin
      slot = SlotWb;
    end else if (fifo_pop) begin
      slot = SlotMd;
    end
  end

  always_comb begin
    rf_wr_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    unique case (slot)
      SlotWb: begin
        rf_wr_d   = 1'b1;
        rf_addr_d = wb_addr;
        rf_data_d = wb_data;
      end
      SlotMd: begin
        rf_wr_d   = 1'b1;
        rf_addr_d = head_addr;
        rf_data_d = head_data;
      end
      default: ;
    endcase
  end

  // Clear before set so a same-cycle reissue of the draining register stays pending.
  always_comb begin
    pend_d = pend_q;
    if (fifo_pop) begin
      pend_d = pend_d & ~reg_bit(head_addr);
    end
    if (md_issue && (md_iaddr != REG_ZERO)) begin
      pend_d = pend_d | reg_bit(md_iaddr);
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_wr_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
      pend_q    <= '0;
    end else begin
      rf_wr_q   <= rf_wr_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
      pend_q    <= pend_d;
    end
  end

  assign rf_wr     = rf_wr_q;
  assign rf_addr   = rf_addr_q;
  assign rf_data   = rf_data_q;
  assign pend_mask = pend_q;

  // The fifo count is only observed through full/empty at this level.
  logic unused_count;
  assign unused_count = ^fifo_count;

endmodule
